tmr_fault_manager: RTL and testbench
====================================

Name: tmr_fault_manager

Overview:
- Supervises a TMR triplet using the registered outputs of the 2-of-3 majority voter (fault_flags, disagreement).
- Filters transient disagreements, detects a persistently faulty core, and resyncs it with a timed core reset, a settle check and bounded retries.
- Retires cores that never recover and raises fatal when majority trust is lost.
- Sits beside the voter in the TMR top; outputs drive per-core reset muxing and a status/IRQ interface.

Parameters:
- PERSIST_CYCLES, 4: consecutive valid samples with a core's flag set before it is declared persistent.
- RESET_CYCLES, 16: cycles core_rst is held for one resync attempt.
- SETTLE_CYCLES, 8: consecutive clean valid samples that count as recovery.
- TIMEOUT_CYCLES, 256: maximum cycles in SETTLE before an attempt counts as failed.
- MAX_RETRIES, 2: extra resync attempts after the first before a core is retired.
- CNT_W, 8: width of the saturating event counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- vote_valid  in  1  fault_flags/disagreement valid this cycle
- fault_flags  in  3  voter fault flags: [2]=A, [1]=B, [0]=C
- disagreement  in  1  voter disagreement flag
- clear_stats  in  1  synchronous clear of fault_cnt_*
- core_rst  out  3  active-high per-core reset request, same bit order
- resync_busy  out  1  high in RESET_CORE or SETTLE
- core_failed  out  3  sticky: core retired
- degraded  out  1  OR of core_failed
- fatal  out  1  sticky: majority no longer trustworthy
- fault_cnt_a / fault_cnt_b / fault_cnt_c  out  CNT_W each  persistent-fault events per core, saturating
- irq  out  1  one-cycle pulse on recovery, retirement or fatal entry

Behaviour:
- Reset (rst=1 at clk edge): FSM=IDLE; all outputs 0; all counters 0. Reset mid-resync aborts immediately; core_rst drops the next cycle.
- Masked flag: a flag is masked when its core_failed bit is set, or when that core is the target in RESET_CORE.
- Per-core persistence counter:
  - increments on vote_valid & flag & !masked;
  - clears on vote_valid & !flag;
  - holds when !vote_valid.
- A core is persistent when its counter reaches PERSIST_CYCLES. This is registered, so FSM action comes one cycle after the PERSIST_CYCLES-th sample.
- FSM states: IDLE, RESET_CORE, SETTLE, FATAL.
- IDLE:
  - Exactly one core persistent: latch target k, increment fault_cnt_k, set attempt=0, go to RESET_CORE.
  - Several cores persistent in the same cycle: go to FATAL.
  - disagreement alone (counter below threshold) takes no action.
- RESET_CORE:
  - core_rst[k]=1 for exactly RESET_CYCLES cycles, then SETTLE. Other core_rst bits stay 0.
- SETTLE:
  - core_rst=0. Counts consecutive valid samples with fault_flags[k]=0; a sample with the flag set restarts the count.
  - SETTLE_CYCLES clean samples: recovered; pulse irq, go to IDLE, clear k's persistence counter.
  - TIMEOUT_CYCLES elapsed without recovery:
    - attempt<MAX_RETRIES: increment attempt, go to RESET_CORE;
    - otherwise: set core_failed[k], pulse irq, go to IDLE.
  - Timeout and recovery in the same cycle: recovery wins.
- Fatal triggers:
  - A non-target, unmasked core becomes persistent during RESET_CORE or SETTLE.
  - A retirement would leave two cores failed.
- FATAL: fatal=1, irq pulses on entry, core_rst=0. Terminal until rst.
- Counters: fault_cnt_* saturate at 2^CNT_W-1. clear_stats clears them; clear_stats wins over a same-cycle increment. clear_stats does not affect core_failed or fatal.
- resync_busy = (state==RESET_CORE)|(state==SETTLE).

Optional Feature:
- Macro: TMR_FM_TRANSIENT_CNT_EN.
- Defined: adds outputs trans_cnt_a, trans_cnt_b, trans_cnt_c (CNT_W each, saturating). Each counts fault bursts that clear before reaching PERSIST_CYCLES, incremented when the persistence counter clears from a nonzero value below threshold. Cleared by clear_stats.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- vote_valid=1, fault_flags=3'b100 for 3 cycles, then 3'b000 -> no core_rst, fault_cnt_a=0; with macro, trans_cnt_a=1.
- fault_flags=3'b010 held 4 samples, then 3'b000 -> core_rst=3'b010 for exactly 16 cycles, starting 1 cycle after the 4th sample; after 8 clean samples irq pulses, fault_cnt_b=1, resync_busy=0.
- fault_flags=3'b001 held indefinitely -> 3 reset attempts of 16 cycles each, each followed by a 256-cycle SETTLE timeout; then core_failed=3'b001, degraded=1, irq pulse, state IDLE.
- C already failed, then fault_flags=3'b100 held past all retries -> retiring A would leave two cores failed -> fatal=1, core_rst=0, fatal stays set until rst.
- During SETTLE for A, fault_flags=3'b110 for 4 samples -> fatal=1; assert rst=1 for one cycle -> every output returns to 0.
- clear_stats=1 in the same cycle fault_cnt_b would increment -> fault_cnt_b=0; core_failed unchanged.

Source files
------------

// File: rtl/tmr_fault_manager.sv
// Supervisor beside the TMR majority voter: filters fault flags, resyncs a persistently
// faulty core with bounded retries, retires it or raises fatal. Optional: TMR_FM_TRANSIENT_CNT_EN.
module tmr_fault_manager #(
   parameter int PERSIST_CYCLES = 4,
   parameter int RESET_CYCLES   = 16,
   parameter int SETTLE_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int MAX_RETRIES    = 2,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vote_valid,
   input  logic [2:0]       fault_flags,
   input  logic             disagreement,
   input  logic             clear_stats,
   output logic [2:0]       core_rst,
   output logic             resync_busy,
   output logic [2:0]       core_failed,
   output logic             degraded,
   output logic             fatal,
   output logic [CNT_W-1:0] fault_cnt_a,
   output logic [CNT_W-1:0] fault_cnt_b,
   output logic [CNT_W-1:0] fault_cnt_c,
`ifdef TMR_FM_TRANSIENT_CNT_EN
   output logic [CNT_W-1:0] trans_cnt_a,
   output logic [CNT_W-1:0] trans_cnt_b,
   output logic [CNT_W-1:0] trans_cnt_c,
`endif
   output logic             irq
);

   localparam int PW   = $clog2(PERSIST_CYCLES + 1);
   localparam int SW   = $clog2(SETTLE_CYCLES + 1);
   localparam int TMAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int AW   = $clog2(MAX_RETRIES + 2);
   localparam logic [PW-1:0] P_MAX  = PW'(PERSIST_CYCLES);
   localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] R_LAST = TW'(RESET_CYCLES - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW-1:0] A_MAX  = AW'(MAX_RETRIES);

   typedef enum logic [1:0] {IDLE, RESET_CORE, SETTLE, FATAL} state_t;

   state_t           state;
   logic [1:0]       target;
   logic [AW-1:0]    attempt;
   logic [TW-1:0]    timer;
   logic [SW-1:0]    clean_cnt;
   logic [PW-1:0]    pcnt [3];
   logic [CNT_W-1:0] fcnt [3];

   logic [2:0] masked;
   logic [2:0] persist;
   logic [2:0] other_persist;
   logic       one_persist;
   logic       multi_persist;
   logic [1:0] new_target;
   logic       clean_smp;
   logic       recover;
   logic       timeout;
   logic       fatal_hit;

   // Any set fault flag already implies disagreement, so the flag itself is not needed.
   logic unused_disagreement;
   assign unused_disagreement = disagreement;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         masked[i]        = core_failed[i] | ((state == RESET_CORE) && (target == 2'(i)));
         persist[i]       = (pcnt[i] == P_MAX) && !core_failed[i];
         other_persist[i] = persist[i] && (target != 2'(i));
      end
      one_persist   = ($countones(persist) == 1);
      multi_persist = ($countones(persist) > 1);
      new_target    = 2'd0;
      if (persist[2])      new_target = 2'd2;
      else if (persist[1]) new_target = 2'd1;
      clean_smp = vote_valid && !fault_flags[target];
      fatal_hit = ((state == RESET_CORE) || (state == SETTLE)) && (|other_persist);
      recover   = (state == SETTLE) && clean_smp && (clean_cnt == S_LAST) && !fatal_hit;
      timeout   = (state == SETTLE) && (timer == T_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) pcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (recover && (target == 2'(i)))
               pcnt[i] <= '0;
            else if (vote_valid && !fault_flags[i])
               pcnt[i] <= '0;
            else if (vote_valid && !masked[i] && (pcnt[i] != P_MAX))
               pcnt[i] <= pcnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         target      <= 2'd0;
         attempt     <= '0;
         timer       <= '0;
         clean_cnt   <= '0;
         core_rst    <= 3'b000;
         core_failed <= 3'b000;
         fatal       <= 1'b0;
         irq         <= 1'b0;
      end else begin
         irq <= 1'b0;
         case (state)
            IDLE: begin
               if (multi_persist) begin
                  state <= FATAL;
                  fatal <= 1'b1;
                  irq   <= 1'b1;
               end else if (one_persist) begin
                  target   <= new_target;
                  attempt  <= '0;
                  timer    <= '0;
                  core_rst <= 3'b001 << new_target;
                  state    <= RESET_CORE;
               end
            end
            RESET_CORE: begin
               if (fatal_hit) begin
                  state    <= FATAL;
                  fatal    <= 1'b1;
                  irq      <= 1'b1;
                  core_rst <= 3'b000;
               end else if (timer == R_LAST) begin
                  core_rst  <= 3'b000;
                  timer     <= '0;
                  clean_cnt <= '0;
                  state     <= SETTLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            SETTLE: begin
               if (fatal_hit) begin
                  state <= FATAL;
                  fatal <= 1'b1;
                  irq   <= 1'b1;
               end else if (recover) begin
                  irq   <= 1'b1;
                  state <= IDLE;
               end else if (timeout) begin
                  // A second retirement would leave no trustworthy majority.
                  if (attempt < A_MAX) begin
                     attempt  <= attempt + 1'b1;
                     timer    <= '0;
                     core_rst <= 3'b001 << target;
                     state    <= RESET_CORE;
                  end else if (|core_failed) begin
                     state <= FATAL;
                     fatal <= 1'b1;
                     irq   <= 1'b1;
                  end else begin
                     core_failed[target] <= 1'b1;
                     irq                 <= 1'b1;
                     state               <= IDLE;
                  end
               end else begin
                  timer <= timer + 1'b1;
                  if (clean_smp)       clean_cnt <= clean_cnt + 1'b1;
                  else if (vote_valid) clean_cnt <= '0;
               end
            end
            FATAL: begin
               core_rst <= 3'b000;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_stats) begin
         for (int i = 0; i < 3; i++) fcnt[i] <= '0;
      end else if ((state == IDLE) && one_persist) begin
         fcnt[new_target] <= sat_inc(fcnt[new_target]);
      end
   end

`ifdef TMR_FM_TRANSIENT_CNT_EN
   logic [CNT_W-1:0] tcnt [3];

   // A burst is transient when its run ends before reaching the persistence threshold.
   always_ff @(posedge clk) begin
      if (rst || clear_stats) begin
         for (int i = 0; i < 3; i++) tcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++)
            if (vote_valid && !fault_flags[i] && (pcnt[i] != '0) && (pcnt[i] != P_MAX))
               tcnt[i] <= sat_inc(tcnt[i]);
      end
   end

   assign trans_cnt_a = tcnt[2];
   assign trans_cnt_b = tcnt[1];
   assign trans_cnt_c = tcnt[0];
`endif

   assign fault_cnt_a = fcnt[2];
   assign fault_cnt_b = fcnt[1];
   assign fault_cnt_c = fcnt[0];
   assign degraded    = |core_failed;
   assign resync_busy = (state == RESET_CORE) || (state == SETTLE);

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Directed bench for tmr_fault_manager with a cycle-level behavioural model and literal checks.
module tb_tmr_fault_manager;

   localparam int P    = 4;
   localparam int RC   = 16;
   localparam int SC   = 8;
   localparam int TC   = 256;
   localparam int MR   = 2;
   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          vote_valid;
   logic [2:0]    fault_flags;
   logic          disagreement;
   logic          clear_stats;
   logic [2:0]    core_rst;
   logic          resync_busy;
   logic [2:0]    core_failed;
   logic          degraded;
   logic          fatal;
   logic [CW-1:0] fault_cnt_a, fault_cnt_b, fault_cnt_c;
`ifdef TMR_FM_TRANSIENT_CNT_EN
   logic [CW-1:0] trans_cnt_a, trans_cnt_b, trans_cnt_c;
`endif
   logic          irq;

   tmr_fault_manager #(
      .PERSIST_CYCLES(P), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC),
      .TIMEOUT_CYCLES(TC), .MAX_RETRIES(MR), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .vote_valid(vote_valid), .fault_flags(fault_flags),
      .disagreement(disagreement), .clear_stats(clear_stats), .core_rst(core_rst),
      .resync_busy(resync_busy), .core_failed(core_failed), .degraded(degraded),
      .fatal(fatal), .fault_cnt_a(fault_cnt_a), .fault_cnt_b(fault_cnt_b),
      .fault_cnt_c(fault_cnt_c),
`ifdef TMR_FM_TRANSIENT_CNT_EN
      .trans_cnt_a(trans_cnt_a), .trans_cnt_b(trans_cnt_b), .trans_cnt_c(trans_cnt_c),
`endif
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: dut=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: run lengths, countdowns and ages rather than a state register.
   bit       m_valid = 0;
   int       m_streak [3];
   int       m_rst_left, m_age, m_clean, m_tries, m_tgt;
   bit       m_settling, m_fatal, m_irq;
   bit [2:0] m_failed;
   int       m_fcnt [3];
   int       m_tcnt [3];

   function automatic int satinc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic enter_fatal();
      m_fatal = 1; m_irq = 1; m_rst_left = 0; m_settling = 0;
   endtask

   always @(posedge clk) begin : model
      bit [2:0] pers;
      int       npers, first;
      bit       busy, other;
      if (rst) begin
         m_valid = 1;
         for (int i = 0; i < 3; i++) begin
            m_streak[i] = 0; m_fcnt[i] = 0; m_tcnt[i] = 0;
         end
         m_rst_left = 0; m_age = 0; m_clean = 0; m_tries = 0; m_tgt = 0;
         m_settling = 0; m_fatal = 0; m_irq = 0; m_failed = 3'b000;
      end else if (m_valid) begin
         m_irq = 0;
         npers = 0; first = -1; pers = 3'b000;
         for (int i = 2; i >= 0; i--) begin
            pers[i] = (m_streak[i] >= P) && !m_failed[i];
            if (pers[i]) begin
               npers++;
               if (first < 0) first = i;
            end
         end
         busy  = (m_rst_left > 0) || m_settling;
         other = 0;
         for (int i = 0; i < 3; i++) if (pers[i] && i != m_tgt) other = 1;
         for (int i = 0; i < 3; i++) begin
            if (vote_valid) begin
               if (!fault_flags[i]) begin
                  if (m_streak[i] > 0 && m_streak[i] < P) m_tcnt[i] = satinc(m_tcnt[i]);
                  m_streak[i] = 0;
               end else if (!(m_failed[i] || (m_rst_left > 0 && m_tgt == i)) && m_streak[i] < P) begin
                  m_streak[i]++;
               end
            end
         end
         if (!m_fatal) begin
            if (!busy) begin
               if (npers > 1) enter_fatal();
               else if (npers == 1) begin
                  m_tgt = first; m_fcnt[first] = satinc(m_fcnt[first]);
                  m_tries = 0; m_rst_left = RC;
               end
            end else if (other) begin
               enter_fatal();
            end else if (m_rst_left > 0) begin
               m_rst_left--;
               if (m_rst_left == 0) begin
                  m_settling = 1; m_age = 0; m_clean = 0;
               end
            end else begin
               m_age++;
               if (vote_valid) m_clean = fault_flags[m_tgt] ? 0 : m_clean + 1;
               if (m_clean >= SC) begin
                  m_settling = 0; m_irq = 1; m_streak[m_tgt] = 0;
               end else if (m_age >= TC) begin
                  m_settling = 0;
                  if (m_tries < MR) begin
                     m_tries++; m_rst_left = RC;
                  end else if (m_failed != 3'b000) begin
                     enter_fatal();
                  end else begin
                     m_failed[m_tgt] = 1; m_irq = 1;
                  end
               end
            end
         end
         if (clear_stats) begin
            for (int i = 0; i < 3; i++) begin
               m_fcnt[i] = 0; m_tcnt[i] = 0;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [2:0] e_rst;
      if (m_valid) begin
         e_rst = (m_rst_left > 0) ? (3'b001 << m_tgt) : 3'b000;
         cmp("core_rst", core_rst, e_rst);
         cmp("resync_busy", resync_busy, (m_rst_left > 0) || m_settling);
         cmp("core_failed", core_failed, m_failed);
         cmp("degraded", degraded, m_failed != 3'b000);
         cmp("fatal", fatal, m_fatal);
         cmp("irq", irq, m_irq);
         cmp("fault_cnt_a", fault_cnt_a, m_fcnt[2]);
         cmp("fault_cnt_b", fault_cnt_b, m_fcnt[1]);
         cmp("fault_cnt_c", fault_cnt_c, m_fcnt[0]);
`ifdef TMR_FM_TRANSIENT_CNT_EN
         cmp("trans_cnt_a", trans_cnt_a, m_tcnt[2]);
         cmp("trans_cnt_b", trans_cnt_b, m_tcnt[1]);
         cmp("trans_cnt_c", trans_cnt_c, m_tcnt[0]);
`endif
      end
   end

   task automatic drive(input bit vv, input bit [2:0] ff, input bit cs);
      @(negedge clk);
      vote_valid = vv; fault_flags = ff; disagreement = |ff; clear_stats = cs;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; vote_valid = 1'b0; fault_flags = 3'b000; disagreement = 1'b0; clear_stats = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      cmp({tag, "_core_rst"}, core_rst, 0);
      cmp({tag, "_busy"}, resync_busy, 0);
      cmp({tag, "_failed"}, core_failed, 0);
      cmp({tag, "_degraded"}, degraded, 0);
      cmp({tag, "_fatal"}, fatal, 0);
      cmp({tag, "_irq"}, irq, 0);
      cmp({tag, "_cnt_a"}, fault_cnt_a, 0);
      cmp({tag, "_cnt_b"}, fault_cnt_b, 0);
      cmp({tag, "_cnt_c"}, fault_cnt_c, 0);
   endtask

   // Runs a core with its flag held through every retry; returns observation index of the end event.
   task automatic hold_until_end(input bit [2:0] ff, output int end_j, output int rises,
                                 output logic irq_at, output logic [2:0] rst_at);
      logic prev;
      end_j = -1; rises = 0; prev = 1'b0; irq_at = 1'b0; rst_at = 3'b111;
      for (int k = 0; k < P; k++) drive(1, ff, 0);
      for (int j = 0; j < 1000; j++) begin
         drive(1, ff, 0);
         if ((|(core_rst & ff)) && !prev) rises++;
         prev = |(core_rst & ff);
         if (core_failed != 3'b000 && ff != 3'b001) begin end
         if ((ff == 3'b001 && core_failed[0]) || fatal) begin
            end_j = j; irq_at = irq; rst_at = core_rst;
            break;
         end
      end
   endtask

   initial begin
      int         first_j, n_rst, irq_j, end_j, rises;
      logic       irq_at;
      logic [2:0] rst_at;

      rst = 1'b1; vote_valid = 1'b0; fault_flags = 3'b000; disagreement = 1'b0; clear_stats = 1'b0;
      do_reset();
      check_all_zero("reset");

      // Transient burst on A shorter than the persistence threshold.
      for (int k = 0; k < 3; k++) drive(1, 3'b100, 0);
      drive(1, 3'b000, 0);
      drive(1, 3'b000, 0);
      cmp("t1_core_rst", core_rst, 0);
      cmp("t1_fault_cnt_a", fault_cnt_a, 0);
`ifdef TMR_FM_TRANSIENT_CNT_EN
      cmp("t1_trans_cnt_a", trans_cnt_a, 1);
`endif

      // B persistent for exactly four samples, then recovers.
      for (int k = 0; k < P; k++) drive(1, 3'b010, 0);
      first_j = -1; n_rst = 0; irq_j = -1;
      for (int j = 0; j < 30; j++) begin
         drive(1, 3'b000, 0);
         if (core_rst == 3'b010) begin
            n_rst++;
            if (first_j < 0) first_j = j;
         end
         if (irq && irq_j < 0) irq_j = j;
      end
      cmp("t2_first_rst_cycle", first_j, 1);
      cmp("t2_rst_len", n_rst, 16);
      cmp("t2_irq_cycle", irq_j, 25);
      cmp("t2_fault_cnt_b", fault_cnt_b, 1);
      cmp("t2_busy", resync_busy, 0);

      // C never recovers: three attempts then retirement.
      hold_until_end(3'b001, end_j, rises, irq_at, rst_at);
      cmp("t3_retire_cycle", end_j, 817);
      cmp("t3_attempts", rises, 3);
      cmp("t3_core_failed", core_failed, 3'b001);
      cmp("t3_degraded", degraded, 1);
      cmp("t3_irq", irq_at, 1);
      cmp("t3_busy", resync_busy, 0);
      cmp("t3_fault_cnt_c", fault_cnt_c, 1);

      // A never recovers with C already retired: fatal instead of second retirement.
      hold_until_end(3'b100, end_j, rises, irq_at, rst_at);
      cmp("t4_fatal_cycle", end_j, 817);
      cmp("t4_attempts", rises, 3);
      cmp("t4_irq", irq_at, 1);
      cmp("t4_core_rst", rst_at, 0);
      cmp("t4_core_failed", core_failed, 3'b001);
      for (int j = 0; j < 20; j++) drive(1, 3'b000, 0);
      cmp("t4_fatal_sticky", fatal, 1);
      cmp("t4_core_rst_idle", core_rst, 0);
      cmp("t4_fault_cnt_a", fault_cnt_a, 1);
      drive(1, 3'b000, 1);
      drive(1, 3'b000, 0);
      cmp("t4_clr_cnt_a", fault_cnt_a, 0);
      cmp("t4_clr_cnt_c", fault_cnt_c, 0);
      cmp("t4_clr_keeps_failed", core_failed, 3'b001);
      cmp("t4_clr_keeps_fatal", fatal, 1);

      // Second core goes persistent while A is settling.
      do_reset();
      check_all_zero("t5_reset");
      for (int k = 0; k < P; k++) drive(1, 3'b100, 0);
      for (int j = 0; j < 17; j++) drive(1, 3'b000, 0);
      drive(1, 3'b110, 0);
      cmp("t5_settle_busy", resync_busy, 1);
      cmp("t5_settle_rst", core_rst, 0);
      for (int k = 1; k < P; k++) drive(1, 3'b110, 0);
      drive(1, 3'b000, 0);
      cmp("t5_not_yet_fatal", fatal, 0);
      drive(1, 3'b000, 0);
      cmp("t5_fatal", fatal, 1);
      cmp("t5_irq", irq, 1);
      do_reset();
      check_all_zero("t5_after_rst");

      // clear_stats on the same edge as B's increment.
      for (int k = 0; k < P; k++) drive(1, 3'b010, 0);
      drive(1, 3'b000, 1);
      drive(1, 3'b000, 0);
      cmp("t6_fault_cnt_b", fault_cnt_b, 0);
      cmp("t6_core_rst", core_rst, 3'b010);
      cmp("t6_core_failed", core_failed, 0);
      drive(1, 3'b000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
